if_fetch_unit: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and runs a req/ack handshake to a variable-latency instruction memory (SRAM controller).
- Holds one fetched instruction in a buffer and presents it, with its PC+4, to the IF/ID register.
- Raises fetch_stall while no valid instruction is available; the top level ORs fetch_stall into the pipeline freeze (superStall).

---
 rtl/if_pkg.sv | 23 ++
 rtl/if_pc_reg.sv | 35 +++
 rtl/if_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch unit: state encoding,
// the NOP word shown when no instruction is buffered, and default
// values for the reset PC and the per-instruction PC increment.
package if_pkg;

  // 2-bit state encoding of the fetch FSM
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_DROP  = ST_DROP,
    S_FULL  = ST_FULL
  } state_t;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEF_PC_INC   = 32'd4;

endpackage

// File: rtl/if_pc_reg.sv
// Program-counter register for the fetch unit. Synchronous active-low
// reset to RESET_PC; a load (branch/redirect target) wins over the
// sequential increment. The incremented value is also exported so the
// fetch unit can record PC+4 alongside the buffered instruction.
module if_pc_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_INC   = DEF_PC_INC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_load_addr,
  input  logic        i_inc,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus
);

  logic [31:0] r_pc;

  // 32-bit add, wraps modulo 2^32 (0xFFFF_FFFC + 4 -> 0)
  assign o_pc_plus = r_pc + PC_INC;
  assign o_pc      = r_pc;

  // pc update: reset, then load, then increment
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    if (!rst)        r_pc <= RESET_PC;
    else if (i_load) r_pc <= i_load_addr;
    else if (i_inc)  r_pc <= o_pc_plus;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register. Owns the PC, runs a
// level req / pulse ack handshake to a variable-latency instruction memory,
// and buffers one instruction with its PC+4. fetch_stall is high whenever
// no valid instruction is presented.
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_wait_cnt outputs.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] PC_INC   = DEF_PC_INC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        superStall,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        fetch_stall
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt
`endif
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic [31:0] r_target;

  logic [31:0] w_pc;
  logic [31:0] w_pc_plus;
  logic        w_pc_load;
  logic [31:0] w_pc_load_addr;
  logic        w_pc_inc;
  logic        w_buf_wr;
  logic        w_buf_clr;
  logic        w_target_wr;
  logic        w_consume;

  if_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_pc_load),
    .i_load_addr (w_pc_load_addr),
    .i_inc       (w_pc_inc),
    .o_pc        (w_pc),
    .o_pc_plus   (w_pc_plus)
  );

  assign w_consume = (r_state == S_FULL) && !stall && !superStall;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // next-state and datapath enables; branch_taken outranks both stalls
  always_comb begin
    // NOTE: every signal gets a default before the case so no path
    // leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt    = r_state;
    w_pc_load      = 1'b0;
    w_pc_load_addr = branch_addr;
    w_pc_inc       = 1'b0;
    w_buf_wr       = 1'b0;
    w_buf_clr      = 1'b0;
    w_target_wr    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        // a stray ack here belongs to an abandoned request: ignore it
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack && branch_taken) begin
          w_pc_load = 1'b1;
        end else if (imem_ack) begin
          w_buf_wr    = 1'b1;
          w_pc_inc    = 1'b1;
          w_state_nxt = S_FULL;
        end else if (branch_taken) begin
          // request in flight: keep the address until the ack arrives
          w_target_wr = 1'b1;
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_ack) begin
          w_pc_load      = 1'b1;
          w_pc_load_addr = branch_taken ? branch_addr : r_target;
          w_state_nxt    = S_FETCH;
        end else if (branch_taken) begin
          w_target_wr = 1'b1;
        end
      end
      S_FULL: begin
        if (branch_taken) begin
          w_pc_load   = 1'b1;
          w_buf_clr   = 1'b1;
          w_state_nxt = S_FETCH;
        end else if (w_consume) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // instruction buffer: captured on an accepted ack, cleared on redirect
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf_instr <= NOP_INSTR;
      r_buf_pc    <= 32'h0;
    end else if (w_buf_wr) begin
      r_buf_instr <= imem_rdata;
      r_buf_pc    <= w_pc_plus;
    end else if (w_buf_clr) begin
      r_buf_instr <= NOP_INSTR;
      r_buf_pc    <= 32'h0;
    end
  end

  // pending redirect target while an abandoned request drains
  always_ff @(posedge clk) begin
    if (!rst)             r_target <= 32'h0;
    else if (w_target_wr) r_target <= branch_addr;
  end

  // Moore outputs decoded from the current state
  always_comb begin
    imem_req    = (r_state == S_FETCH) || (r_state == S_DROP);
    imem_addr   = w_pc;
    fetch_stall = (r_state != S_FULL);
    Instruction = (r_state == S_FULL) ? r_buf_instr : NOP_INSTR;
    PC          = (r_state == S_FULL) ? r_buf_pc : 32'h0;
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_wait_cnt;

  // accepted fetches and memory wait cycles, both wrapping at 2^32
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_fetch_cnt <= 32'h0;
      r_perf_wait_cnt  <= 32'h0;
    end else begin
      if (w_buf_wr)              r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      if (imem_req && !imem_ack) r_perf_wait_cnt  <= r_perf_wait_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt = r_perf_fetch_cnt;
  assign perf_wait_cnt  = r_perf_wait_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus a
// randomized run checked against a program-order instruction-stream model.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        superStall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic        fetch_stall;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_wait_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // memory responder configuration
  bit mem_en   = 1'b1;
  bit mem_rand = 1'b0;
  int mem_wait = 0;
  bit mem_busy = 1'b0;
  int mem_left = 0;

  if_fetch_unit #(.RESET_PC(RESET_PC), .PC_INC(32'd4)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .superStall   (superStall),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .Instruction  (Instruction),
    .PC           (PC),
    .fetch_stall  (fetch_stall)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory contents: a fixed scramble of the address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // decide ack/rdata for the coming edge from the current request
  task automatic mem_drive();
    if (!mem_en) return;
    if (imem_req === 1'b1) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_left = mem_rand ? int'($urandom_range(0, 3)) : mem_wait;
      end
      if (mem_left == 0) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        mem_busy   = 1'b0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        mem_left   = mem_left - 1;
      end
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      mem_busy   = 1'b0;
    end
  endtask

  // one clock: outputs are sampled 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    mem_drive();
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; superStall = 1'b0;
    branch_taken = 1'b0; branch_addr = 32'h0;
    mem_en = 1'b1; mem_rand = 1'b0; mem_wait = 0; mem_busy = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // zero-wait run until the buffer holds the instruction whose PC+4 is a
  task automatic goto_full(input logic [31:0] a);
    bit found = 1'b0;
    mem_rand = 1'b0; mem_wait = 0;
    stall = 1'b0; superStall = 1'b0; branch_taken = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (fetch_stall === 1'b0 && PC === a) found = 1'b1;
      else step();
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL goto_full: never presented PC=%h within 200 cycles", a);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (imem_req !== 1'b0 || Instruction !== 32'h0 || PC !== 32'h0 || fetch_stall !== 1'b1) begin
      n_err++;
      $display("FAIL reset_state: req=%b instr=%h pc=%h stall=%b, expected 0/0/0/1",
               imem_req, Instruction, PC, fetch_stall);
    end
  endtask

  task automatic test_zero_wait();
    do_reset();
    mem_wait = 0;
    step();
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || fetch_stall !== 1'b1) begin
        n_err++;
        $display("FAIL zw_fetch[%0d]: req=%b addr=%h stall=%b, expected 1/%h/1",
                 k, imem_req, imem_addr, fetch_stall, 32'(4 * k));
      end
      step();
      n_cmp++;
      if (Instruction !== mem_word(32'(4 * k)) || PC !== 32'(4 * k + 4) ||
          fetch_stall !== 1'b0 || imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL zw_full[%0d]: instr=%h pc=%h stall=%b req=%b, expected %h/%h/0/0",
                 k, Instruction, PC, fetch_stall, imem_req, mem_word(32'(4 * k)), 32'(4 * k + 4));
      end
      step();
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    goto_full(32'h10);
    mem_wait = 3;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10 || fetch_stall !== 1'b1) begin
        n_err++;
        $display("FAIL wait_hold[%0d]: req=%b addr=%h stall=%b, expected 1/00000010/1",
                 i, imem_req, imem_addr, fetch_stall);
      end
    end
    step();
    n_cmp++;
    if (fetch_stall !== 1'b0 || Instruction !== mem_word(32'h10) || PC !== 32'h14) begin
      n_err++;
      $display("FAIL wait_full: stall=%b instr=%h pc=%h, expected 0/%h/00000014",
               fetch_stall, Instruction, PC, mem_word(32'h10));
    end
  endtask

  // continues from the FULL state left by test_wait_states
  task automatic test_stall_hold();
    mem_wait = 0;
    stall = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i == 5) begin stall = 1'b0; superStall = 1'b1; end
      step();
      n_cmp++;
      if (Instruction !== mem_word(32'h10) || PC !== 32'h14 || imem_req !== 1'b0 || fetch_stall !== 1'b0) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: instr=%h pc=%h req=%b stall=%b, expected %h/00000014/0/0",
                 i, Instruction, PC, imem_req, fetch_stall, mem_word(32'h10));
      end
    end
    superStall = 1'b0;
    step();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h14) begin
      n_err++;
      $display("FAIL stall_release: req=%b addr=%h, expected 1/00000014", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_in_wait();
    int cnt = 0;
    do_reset();
    goto_full(32'h40);
    mem_wait = 3;
    step();
    branch_taken = 1'b1; branch_addr = 32'h200;
    step();
    branch_taken = 1'b0; branch_addr = 32'h0;
    mem_wait = 0;
    while (imem_ack !== 1'b1 && cnt < 10) begin
      n_cmp++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40 || fetch_stall !== 1'b1) begin
        n_err++;
        $display("FAIL drop_hold[%0d]: req=%b addr=%h stall=%b, expected 1/00000040/1",
                 cnt, imem_req, imem_addr, fetch_stall);
      end
      step();
      cnt++;
    end
    n_cmp++;
    if (imem_ack !== 1'b1 || imem_addr !== 32'h40) begin
      n_err++;
      $display("FAIL drop_ack: ack=%b addr=%h, expected 1/00000040", imem_ack, imem_addr);
    end
    step();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || fetch_stall !== 1'b1 || Instruction !== 32'h0) begin
      n_err++;
      $display("FAIL drop_redirect: req=%b addr=%h stall=%b instr=%h, expected 1/00000200/1/0",
               imem_req, imem_addr, fetch_stall, Instruction);
    end
    step();
    n_cmp++;
    if (Instruction !== mem_word(32'h200) || PC !== 32'h204) begin
      n_err++;
      $display("FAIL drop_target_full: instr=%h pc=%h, expected %h/00000204",
               Instruction, PC, mem_word(32'h200));
    end
  endtask

  // continues from FULL holding the instruction at 0x200
  task automatic test_branch_in_full();
    stall = 1'b1; branch_taken = 1'b1; branch_addr = 32'h80;
    step();
    branch_taken = 1'b0; stall = 1'b0;
    n_cmp++;
    if (fetch_stall !== 1'b1 || Instruction !== 32'h0 || PC !== 32'h0 ||
        imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      n_err++;
      $display("FAIL full_branch: stall=%b instr=%h pc=%h req=%b addr=%h, expected 1/0/0/1/00000080",
               fetch_stall, Instruction, PC, imem_req, imem_addr);
    end
    step();
    n_cmp++;
    if (Instruction !== mem_word(32'h80) || PC !== 32'h84) begin
      n_err++;
      $display("FAIL full_branch_next: instr=%h pc=%h, expected %h/00000084",
               Instruction, PC, mem_word(32'h80));
    end
  endtask

  task automatic test_reset_mid_and_wrap();
    do_reset();
    goto_full(32'h24);
    mem_en = 1'b0; imem_ack = 1'b0;
    step();
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin
      n_err++;
      $display("FAIL mid_req: req=%b addr=%h, expected 1/00000024", imem_req, imem_addr);
    end
    rst = 1'b0;
    step();
    n_cmp++;
    if (imem_req !== 1'b0 || fetch_stall !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: req=%b stall=%b, expected 0/1", imem_req, fetch_stall);
    end
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    n_cmp++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC || fetch_stall !== 1'b1) begin
      n_err++;
      $display("FAIL late_ack: req=%b addr=%h stall=%b, expected 1/%h/1",
               imem_req, imem_addr, fetch_stall, RESET_PC);
    end
    mem_en = 1'b1; mem_busy = 1'b0; mem_wait = 0;
    mem_drive();
    step();
    n_cmp++;
    if (Instruction !== mem_word(RESET_PC) || PC !== RESET_PC + 32'd4) begin
      n_err++;
      $display("FAIL late_ack_full: instr=%h pc=%h, expected %h/%h",
               Instruction, PC, mem_word(RESET_PC), RESET_PC + 32'd4);
    end
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    n_cmp++;
    if (imem_addr !== 32'hFFFF_FFFC || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_fetch: addr=%h req=%b, expected fffffffc/1", imem_addr, imem_req);
    end
    step();
    n_cmp++;
    if (Instruction !== mem_word(32'hFFFF_FFFC) || PC !== 32'h0 || fetch_stall !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_full: instr=%h pc=%h stall=%b, expected %h/00000000/0",
               Instruction, PC, fetch_stall, mem_word(32'hFFFF_FFFC));
    end
    step();
    n_cmp++;
    if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin
      n_err++;
      $display("FAIL wrap_next: addr=%h req=%b, expected 00000000/1", imem_addr, imem_req);
    end
  endtask

  // random stalls, branches and memory latency; the model tracks only the
  // address of the next instruction expected in program order
  task automatic test_random();
    logic [31:0] exp_pc;
    logic [31:0] prev_addr;
    logic        prev_req;
    logic        prev_ack;
    logic        br;
    int          consumed = 0;
    do_reset();
    mem_rand = 1'b1;
    exp_pc = RESET_PC; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (fetch_stall !== 1'b0) begin
        n_cmp++;
        if (Instruction !== 32'h0 || PC !== 32'h0 || fetch_stall !== 1'b1) begin
          n_err++;
          $display("FAIL rnd_nop cyc=%0d: instr=%h pc=%h stall=%b, expected 0/0/1",
                   cyc, Instruction, PC, fetch_stall);
        end
      end else begin
        n_cmp++;
        if (Instruction !== mem_word(exp_pc) || PC !== exp_pc + 32'd4 || imem_req !== 1'b0) begin
          n_err++;
          $display("FAIL rnd_stream cyc=%0d: instr=%h pc=%h req=%b, expected %h/%h/0",
                   cyc, Instruction, PC, imem_req, mem_word(exp_pc), exp_pc + 32'd4);
        end
      end
      if (prev_req && !prev_ack) begin
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_err++;
          $display("FAIL rnd_hold cyc=%0d: req=%b addr=%h, expected 1/%h",
                   cyc, imem_req, imem_addr, prev_addr);
        end
      end
      prev_req  = (imem_req === 1'b1);
      prev_ack  = (imem_ack === 1'b1);
      prev_addr = imem_addr;
      stall      = ($urandom_range(0, 3) == 0);
      superStall = ($urandom_range(0, 6) == 0);
      br = ((imem_req === 1'b1) || (fetch_stall === 1'b0)) && ($urandom_range(0, 9) == 0);
      branch_taken = br;
      branch_addr  = $urandom & 32'h0003_FFFC;
      if (br) exp_pc = branch_addr;
      else if (fetch_stall === 1'b0 && !stall && !superStall) begin
        exp_pc = exp_pc + 32'd4;
        consumed++;
      end
      step();
    end
    stall = 1'b0; superStall = 1'b0; branch_taken = 1'b0;
    n_cmp++;
    if (consumed < 30) begin
      n_err++;
      $display("FAIL rnd_progress: consumed=%0d, expected at least 30", consumed);
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; superStall = 1'b0;
    branch_taken = 1'b0; branch_addr = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_stall_hold();
    test_branch_in_wait();
    test_branch_in_full();
    test_reset_mid_and_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // guards against a hung run
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
